// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-field bit
// positions and the decoded-control bundle with its opcode decoder.
package id_pkg;

  localparam int REG_W = 5;
  localparam int OPC_W = 6;
  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  localparam int MEM_BRANCH  = 2;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic             illegal;
    logic             use_rs;
    logic             use_rt;
    logic             rtype;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPC_W-1:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_RTYPE: begin
        c.ex[EX_REGDST]   = 1'b1;
        c.ex[EX_ALUOP_HI] = 1'b1;
        c.wb[WB_REGWRITE] = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.rtype  = 1'b1;
      end
      OP_LW: begin
        c.ex[EX_ALUSRC]   = 1'b1;
        c.mem[MEM_READ]   = 1'b1;
        c.wb[WB_REGWRITE] = 1'b1;
        c.wb[WB_MEMTOREG] = 1'b1;
        c.use_rs = 1'b1;
      end
      OP_SW: begin
        c.ex[EX_ALUSRC]  = 1'b1;
        c.mem[MEM_WRITE] = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.ex[EX_ALUOP_LO] = 1'b1;
        c.mem[MEM_BRANCH] = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
      end
      OP_J: ;
      OP_ADDI: begin
        c.ex[EX_ALUSRC]   = 1'b1;
        c.wb[WB_REGWRITE] = 1'b1;
        c.use_rs = 1'b1;
      end
      default: begin
        c.illegal = 1'b1;
        c.use_rs  = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file, two asynchronous read ports and one write port.
// A write in the same cycle is visible on the read ports; r0 is hardwired 0.
module regfile_2r1w
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  input  logic             we,
  input  logic [REG_W-1:0] wa,
  input  logic [XLEN-1:0]  wd
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && wa != '0) regs_d[wa] = wd;
  end

  // Reading the next-state array gives write-first bypass for free.
  assign rd1 = (ra1 == '0) ? '0 : regs_d[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_d[ra2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/id_stage_hz.sv
// MIPS decode stage: register read, branch/jump resolution in ID, load-use
// and branch-operand hazard detection, and the ID/EX pipeline register.
module id_stage_hz
  import id_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int BRANCH_FWD = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc4,
  input  logic [31:0]      if_instr,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_dst,
  input  logic [XLEN-1:0]  mem_alu,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_dst,
  input  logic [XLEN-1:0]  wb_data,
  output logic             if_stall,
  output logic             if_flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             id_ex_valid,
  output logic             id_ex_illegal,
  output logic [XLEN-1:0]  id_ex_pc4,
  output logic [XLEN-1:0]  id_ex_rd1,
  output logic [XLEN-1:0]  id_ex_rd2,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic [REG_W-1:0] id_ex_rs,
  output logic [REG_W-1:0] id_ex_rt,
  output logic [REG_W-1:0] id_ex_rd,
  output logic [REG_W-1:0] id_ex_dst,
  output logic [EX_W-1:0]  id_ex_ex,
  output logic [MEM_W-1:0] id_ex_mem,
  output logic [WB_W-1:0]  id_ex_wb,
  output logic [CNT_W-1:0] stall_count
);

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] rs, rt, rd;
  logic [XLEN-1:0]  imm_ext, rf_rd1, rf_rd2, cmp_a, cmp_b;
  ctrl_t            dec;

  assign opcode  = if_instr[31:26];
  assign rs      = if_instr[25:21];
  assign rt      = if_instr[20:16];
  assign rd      = if_instr[15:11];
  assign imm_ext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
  assign dec     = decode(opcode);

  regfile_2r1w #(.XLEN(XLEN)) u_rf (
    .clk(clk), .rst(rst),
    .ra1(rs), .ra2(rt), .rd1(rf_rd1), .rd2(rf_rd2),
    .we(wb_regwrite), .wa(wb_dst), .wd(wb_data)
  );

  logic [REG_W-1:0] id_ex_dst_q;
  logic             id_ex_valid_q;
  logic [MEM_W-1:0] id_ex_mem_q;
  logic [WB_W-1:0]  id_ex_wb_q;

  // Sources that can hazard: used by this opcode and not r0.
  logic use_rs, use_rt, is_beq, is_bne, is_br, is_j;
  assign use_rs = if_valid & dec.use_rs & (rs != '0);
  assign use_rt = if_valid & dec.use_rt & (rt != '0);
  assign is_beq = if_valid & (opcode == OP_BEQ);
  assign is_bne = if_valid & (opcode == OP_BNE);
  assign is_br  = is_beq | is_bne;
  assign is_j   = if_valid & (opcode == OP_J);

  logic ex_hit, mem_hit_rs, mem_hit_rt, mem_alu_rs, mem_alu_rt;
  logic load_use, br_stall, hazard, taken;
  assign ex_hit     = id_ex_valid_q & ((use_rs & (id_ex_dst_q == rs)) |
                                       (use_rt & (id_ex_dst_q == rt)));
  assign mem_hit_rs = use_rs & (mem_dst == rs);
  assign mem_hit_rt = use_rt & (mem_dst == rt);
  assign mem_alu_rs = mem_regwrite & ~mem_memread & mem_hit_rs;
  assign mem_alu_rt = mem_regwrite & ~mem_memread & mem_hit_rt;

  assign load_use = ex_hit & id_ex_mem_q[MEM_READ] & (id_ex_dst_q != '0);
  assign br_stall = is_br & ((ex_hit & id_ex_wb_q[WB_REGWRITE]) |
                             (mem_memread & (mem_hit_rs | mem_hit_rt)) |
                             ((BRANCH_FWD == 0) & (mem_alu_rs | mem_alu_rt)));
  assign hazard   = load_use | br_stall;

  assign cmp_a = ((BRANCH_FWD != 0) && mem_alu_rs) ? mem_alu : rf_rd1;
  assign cmp_b = ((BRANCH_FWD != 0) && mem_alu_rt) ? mem_alu : rf_rd2;
  assign taken = (is_beq & (cmp_a == cmp_b)) | (is_bne & (cmp_a != cmp_b)) | is_j;

  // Outputs are forced quiet while reset is held; stall beats redirect.
  assign if_stall       = rst & hazard;
  assign redirect_valid = rst & ~hazard & taken;
  assign if_flush       = redirect_valid;
  assign redirect_pc    = is_j ? {if_pc4[XLEN-1:28], if_instr[25:0], 2'b00}
                               : if_pc4 + (imm_ext << 2);

  logic             id_ex_valid_d, id_ex_illegal_q, id_ex_illegal_d;
  logic [XLEN-1:0]  id_ex_pc4_q, id_ex_pc4_d, id_ex_rd1_q, id_ex_rd1_d;
  logic [XLEN-1:0]  id_ex_rd2_q, id_ex_rd2_d, id_ex_imm_q, id_ex_imm_d;
  logic [REG_W-1:0] id_ex_rs_q, id_ex_rs_d, id_ex_rt_q, id_ex_rt_d;
  logic [REG_W-1:0] id_ex_rd_q, id_ex_rd_d, id_ex_dst_d;
  logic [EX_W-1:0]  id_ex_ex_q, id_ex_ex_d;
  logic [MEM_W-1:0] id_ex_mem_d;
  logic [WB_W-1:0]  id_ex_wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // rd1/rd2 carry the register-file values; EX resolves its own forwarding.
  always_comb begin
    id_ex_valid_d   = if_valid & ~hazard;
    id_ex_illegal_d = id_ex_valid_d & dec.illegal;
    id_ex_ex_d      = id_ex_valid_d ? dec.ex  : '0;
    id_ex_mem_d     = id_ex_valid_d ? dec.mem : '0;
    id_ex_wb_d      = id_ex_valid_d ? dec.wb  : '0;
    id_ex_pc4_d     = if_pc4;
    id_ex_rd1_d     = rf_rd1;
    id_ex_rd2_d     = rf_rd2;
    id_ex_imm_d     = imm_ext;
    id_ex_rs_d      = rs;
    id_ex_rt_d      = rt;
    id_ex_rd_d      = rd;
    id_ex_dst_d     = dec.rtype ? rd : rt;
    stall_count_d   = stall_count_q;
    if (hazard && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_valid_q   <= 1'b0;
      id_ex_illegal_q <= 1'b0;
      id_ex_pc4_q     <= '0;
      id_ex_rd1_q     <= '0;
      id_ex_rd2_q     <= '0;
      id_ex_imm_q     <= '0;
      id_ex_rs_q      <= '0;
      id_ex_rt_q      <= '0;
      id_ex_rd_q      <= '0;
      id_ex_dst_q     <= '0;
      id_ex_ex_q      <= '0;
      id_ex_mem_q     <= '0;
      id_ex_wb_q      <= '0;
      stall_count_q   <= '0;
    end else begin
      id_ex_valid_q   <= id_ex_valid_d;
      id_ex_illegal_q <= id_ex_illegal_d;
      id_ex_pc4_q     <= id_ex_pc4_d;
      id_ex_rd1_q     <= id_ex_rd1_d;
      id_ex_rd2_q     <= id_ex_rd2_d;
      id_ex_imm_q     <= id_ex_imm_d;
      id_ex_rs_q      <= id_ex_rs_d;
      id_ex_rt_q      <= id_ex_rt_d;
      id_ex_rd_q      <= id_ex_rd_d;
      id_ex_dst_q     <= id_ex_dst_d;
      id_ex_ex_q      <= id_ex_ex_d;
      id_ex_mem_q     <= id_ex_mem_d;
      id_ex_wb_q      <= id_ex_wb_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign id_ex_valid   = id_ex_valid_q;
  assign id_ex_illegal = id_ex_illegal_q;
  assign id_ex_pc4     = id_ex_pc4_q;
  assign id_ex_rd1     = id_ex_rd1_q;
  assign id_ex_rd2     = id_ex_rd2_q;
  assign id_ex_imm     = id_ex_imm_q;
  assign id_ex_rs      = id_ex_rs_q;
  assign id_ex_rt      = id_ex_rt_q;
  assign id_ex_rd      = id_ex_rd_q;
  assign id_ex_dst     = id_ex_dst_q;
  assign id_ex_ex      = id_ex_ex_q;
  assign id_ex_mem     = id_ex_mem_q;
  assign id_ex_wb      = id_ex_wb_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: directed instruction sequences push the
// expected ID/EX bundles; a negedge monitor pops and compares them.
module tb_id_stage_hz;
  import id_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_valid, mem_regwrite, mem_memread, wb_regwrite;
  logic [31:0] if_pc4, if_instr, mem_alu, wb_data;
  logic [4:0]  mem_dst, wb_dst;

  logic        if_stall, if_flush, redirect_valid, id_ex_valid, id_ex_illegal;
  logic [31:0] redirect_pc, id_ex_pc4, id_ex_rd1, id_ex_rd2, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_dst;
  logic [3:0]  id_ex_ex;
  logic [2:0]  id_ex_mem;
  logic [1:0]  id_ex_wb;
  logic [15:0] stall_count;

  logic        f0_if_stall, f0_if_flush, f0_redirect_valid, f0_valid, f0_illegal;
  logic [31:0] f0_redirect_pc, f0_pc4, f0_rd1, f0_rd2, f0_imm;
  logic [4:0]  f0_rs, f0_rt, f0_rd, f0_dst;
  logic [3:0]  f0_ex;
  logic [2:0]  f0_mem;
  logic [1:0]  f0_wb;
  logic [1:0]  f0_stall_count;

  id_stage_hz #(.XLEN(32), .BRANCH_FWD(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc4(if_pc4), .if_instr(if_instr),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_dst(mem_dst),
    .mem_alu(mem_alu), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .if_stall(if_stall), .if_flush(if_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ex_valid(id_ex_valid), .id_ex_illegal(id_ex_illegal),
    .id_ex_pc4(id_ex_pc4), .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_dst(id_ex_dst), .id_ex_ex(id_ex_ex), .id_ex_mem(id_ex_mem),
    .id_ex_wb(id_ex_wb), .stall_count(stall_count)
  );

  // Second instance: no branch forwarding and a 2-bit counter that saturates.
  id_stage_hz #(.XLEN(32), .BRANCH_FWD(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc4(if_pc4), .if_instr(if_instr),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_dst(mem_dst),
    .mem_alu(mem_alu), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .if_stall(f0_if_stall), .if_flush(f0_if_flush), .redirect_valid(f0_redirect_valid),
    .redirect_pc(f0_redirect_pc), .id_ex_valid(f0_valid), .id_ex_illegal(f0_illegal),
    .id_ex_pc4(f0_pc4), .id_ex_rd1(f0_rd1), .id_ex_rd2(f0_rd2),
    .id_ex_imm(f0_imm), .id_ex_rs(f0_rs), .id_ex_rt(f0_rt), .id_ex_rd(f0_rd),
    .id_ex_dst(f0_dst), .id_ex_ex(f0_ex), .id_ex_mem(f0_mem),
    .id_ex_wb(f0_wb), .stall_count(f0_stall_count)
  );

  typedef struct packed {
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd, dst;
    logic [3:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic        ill;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic void expect_txn(input logic [31:0] pc4, input logic [31:0] rd1, input logic [31:0] rd2,
                                     input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] dst, input logic [3:0] ex,
                                     input logic [2:0] mem, input logic [1:0] wb, input logic ill);
    txn_t t;
    t = '{pc4: pc4, rd1: rd1, rd2: rd2, imm: imm, rs: rs, rt: rt, rd: rd, dst: dst,
          ex: ex, mem: mem, wb: wb, ill: ill};
    exp_q.push_back(t);
  endfunction

  always @(negedge clk) begin
    txn_t e;
    if (rst === 1'b1 && id_ex_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_txn: got valid pc4=0x%0h, required no transaction", id_ex_pc4);
      end else begin
        e = exp_q.pop_front();
        $display("txn pc4=0x%08h rd1=0x%08h rd2=0x%08h imm=0x%08h dst=%0d ex=%b mem=%b wb=%b ill=%b",
                 id_ex_pc4, id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_dst, id_ex_ex, id_ex_mem,
                 id_ex_wb, id_ex_illegal);
        chk("id_ex.pc4", 64'(id_ex_pc4), 64'(e.pc4));
        chk("id_ex.rd1", 64'(id_ex_rd1), 64'(e.rd1));
        chk("id_ex.rd2", 64'(id_ex_rd2), 64'(e.rd2));
        chk("id_ex.imm", 64'(id_ex_imm), 64'(e.imm));
        chk("id_ex.rs", 64'(id_ex_rs), 64'(e.rs));
        chk("id_ex.rt", 64'(id_ex_rt), 64'(e.rt));
        chk("id_ex.rd", 64'(id_ex_rd), 64'(e.rd));
        chk("id_ex.dst", 64'(id_ex_dst), 64'(e.dst));
        chk("id_ex.ex", 64'(id_ex_ex), 64'(e.ex));
        chk("id_ex.mem", 64'(id_ex_mem), 64'(e.mem));
        chk("id_ex.wb", 64'(id_ex_wb), 64'(e.wb));
        chk("id_ex.illegal", 64'(id_ex_illegal), 64'(e.ill));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    if_valid = v;
    if_instr = instr;
    if_pc4   = pc4;
  endtask

  // One cycle: check combinational hazard/redirect outputs at negedge, then
  // take the edge and return the MEM/WB sideband inputs to idle.
  task automatic cyc(input string tag, input logic es, input logic es0, input logic er,
                     input logic [31:0] epc);
    @(negedge clk);
    chk({tag, ".if_stall"}, 64'(if_stall), 64'(es));
    chk({tag, ".f0_if_stall"}, 64'(f0_if_stall), 64'(es0));
    chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(er));
    chk({tag, ".if_flush"}, 64'(if_flush), 64'(er));
    if (er) chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(epc));
    @(posedge clk);
    #1;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_dst = 5'd0; mem_alu = 32'd0;
    wb_regwrite  = 1'b0; wb_dst      = 5'd0; wb_data = 32'd0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 64'(id_ex_valid), 64'd0);
    chk({tag, ".illegal"}, 64'(id_ex_illegal), 64'd0);
    chk({tag, ".pc4"}, 64'(id_ex_pc4), 64'd0);
    chk({tag, ".rd1"}, 64'(id_ex_rd1), 64'd0);
    chk({tag, ".rd2"}, 64'(id_ex_rd2), 64'd0);
    chk({tag, ".imm"}, 64'(id_ex_imm), 64'd0);
    chk({tag, ".regs"}, 64'({id_ex_rs, id_ex_rt, id_ex_rd, id_ex_dst}), 64'd0);
    chk({tag, ".ctrl"}, 64'({id_ex_ex, id_ex_mem, id_ex_wb}), 64'd0);
    chk({tag, ".stall_count"}, 64'(stall_count), 64'd0);
    chk({tag, ".f0_stall_count"}, 64'(f0_stall_count), 64'd0);
    chk({tag, ".if_stall"}, 64'(if_stall), 64'd0);
    chk({tag, ".if_flush"}, 64'(if_flush), 64'd0);
    chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, {6'h02, 26'h0100000}, 32'h8000_0004);
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_dst = 5'd0; mem_alu = 32'd0;
    wb_regwrite  = 1'b0; wb_dst      = 5'd0; wb_data = 32'd0;

    // Reset with a jump presented: redirect must stay quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");
    @(posedge clk);
    #1;
    drive(1'b0, 32'd0, 32'd0);
    rst = 1'b1;

    wb_regwrite = 1'b1; wb_dst = 5'd1; wb_data = 32'h100; cyc("pre1", 0, 0, 0, 0);
    wb_regwrite = 1'b1; wb_dst = 5'd4; wb_data = 32'h11;  cyc("pre4", 0, 0, 0, 0);
    wb_regwrite = 1'b1; wb_dst = 5'd6; wb_data = 32'h7;   cyc("pre6", 0, 0, 0, 0);

    // Load-use: lw $2,0($1); add $3,$2,$4
    drive(1'b1, enc_i(OP_LW, 5'd1, 5'd2, 16'h0), 32'h4);
    expect_txn(32'h4, 32'h100, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 5'd2, 4'b0001, 3'b010, 2'b11, 1'b0);
    cyc("lu_lw", 0, 0, 0, 0);
    drive(1'b1, enc_r(5'd2, 5'd4, 5'd3), 32'h8);
    cyc("lu_stall", 1, 1, 0, 0);
    chk("lu.bubble_valid", 64'(id_ex_valid), 64'd0);
    chk("lu.bubble_ctrl", 64'({id_ex_ex, id_ex_mem, id_ex_wb}), 64'd0);
    expect_txn(32'h8, 32'h0, 32'h11, 32'h1820, 5'd2, 5'd4, 5'd3, 5'd3, 4'b1100, 3'b000, 2'b10, 1'b0);
    cyc("lu_add", 0, 0, 0, 0);
    chk("lu.stall_count", 64'(stall_count), 64'd1);

    // Branch on ALU result two ahead: add $5; nop; beq $5,$6 with mem_alu=7
    drive(1'b1, enc_r(5'd1, 5'd4, 5'd5), 32'hC);
    expect_txn(32'hC, 32'h100, 32'h11, 32'h2820, 5'd1, 5'd4, 5'd5, 5'd5, 4'b1100, 3'b000, 2'b10, 1'b0);
    cyc("bf_add", 0, 0, 0, 0);
    drive(1'b1, 32'h0, 32'h10);
    expect_txn(32'h10, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1100, 3'b000, 2'b10, 1'b0);
    cyc("bf_nop", 0, 0, 0, 0);
    drive(1'b1, enc_i(OP_BEQ, 5'd5, 5'd6, 16'h4), 32'h100);
    mem_regwrite = 1'b1; mem_dst = 5'd5; mem_alu = 32'h7;
    expect_txn(32'h100, 32'h0, 32'h7, 32'h4, 5'd5, 5'd6, 5'd0, 5'd6, 4'b0010, 3'b100, 2'b00, 1'b0);
    cyc("bf_beq", 0, 1, 1, 32'h110);
    drive(1'b0, 32'h0, 32'h0);
    cyc("bf_flush", 0, 0, 0, 0);

    // Branch right after a load: lw $8; bne $8,$0,-2 -> two stalls
    drive(1'b1, enc_i(OP_LW, 5'd1, 5'd8, 16'h0), 32'h200);
    expect_txn(32'h200, 32'h100, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 5'd8, 4'b0001, 3'b010, 2'b11, 1'b0);
    cyc("bl_lw", 0, 0, 0, 0);
    drive(1'b1, enc_i(OP_BNE, 5'd8, 5'd0, 16'hFFFE), 32'h204);
    cyc("bl_stall1", 1, 1, 0, 0);
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_dst = 5'd8; mem_alu = 32'h0;
    cyc("bl_stall2", 1, 1, 0, 0);
    chk("bl.stall_count", 64'(stall_count), 64'd3);
    chk("bl.f0_stall_count_sat", 64'(f0_stall_count), 64'd3);
    wb_regwrite = 1'b1; wb_dst = 5'd8; wb_data = 32'h55;
    expect_txn(32'h204, 32'h55, 32'h0, 32'hFFFF_FFFE, 5'd8, 5'd0, 5'd31, 5'd0, 4'b0010, 3'b100, 2'b00, 1'b0);
    cyc("bl_bne", 0, 0, 1, 32'h1FC);
    drive(1'b0, 32'h0, 32'h0);
    cyc("bl_flush", 0, 0, 0, 0);

    // Jump
    drive(1'b1, {6'h02, 26'h0100000}, 32'h8000_0004);
    expect_txn(32'h8000_0004, 32'h0, 32'h0, 32'h0, 5'd0, 5'd16, 5'd0, 5'd16, 4'b0000, 3'b000, 2'b00, 1'b0);
    cyc("jmp", 0, 0, 1, 32'h8040_0000);
    drive(1'b0, 32'h0, 32'h0);
    cyc("jmp_flush", 0, 0, 0, 0);

    // WB bypass, write to $0 ignored, unknown opcode
    drive(1'b1, enc_i(OP_ADDI, 5'd7, 5'd9, 16'h1), 32'h300);
    wb_regwrite = 1'b1; wb_dst = 5'd7; wb_data = 32'hDEAD_BEEF;
    expect_txn(32'h300, 32'hDEAD_BEEF, 32'h0, 32'h1, 5'd7, 5'd9, 5'd0, 5'd9, 4'b0001, 3'b000, 2'b10, 1'b0);
    cyc("wb_addi", 0, 0, 0, 0);
    drive(1'b1, enc_r(5'd0, 5'd7, 5'd10), 32'h304);
    wb_regwrite = 1'b1; wb_dst = 5'd0; wb_data = 32'h1234;
    expect_txn(32'h304, 32'h0, 32'hDEAD_BEEF, 32'h5020, 5'd0, 5'd7, 5'd10, 5'd10, 4'b1100, 3'b000, 2'b10, 1'b0);
    cyc("wb_r0", 0, 0, 0, 0);
    drive(1'b1, enc_i(6'h3F, 5'd1, 5'd2, 16'h0), 32'h308);
    expect_txn(32'h308, 32'h100, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 5'd2, 4'b0000, 3'b000, 2'b00, 1'b1);
    cyc("illegal", 0, 0, 0, 0);
    drive(1'b0, 32'h0, 32'h0);
    cyc("idle", 0, 0, 0, 0);

    // Reset asserted in the middle of a load-use stall
    drive(1'b1, enc_i(OP_LW, 5'd1, 5'd2, 16'h0), 32'h400);
    expect_txn(32'h400, 32'h100, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 5'd2, 4'b0001, 3'b010, 2'b11, 1'b0);
    cyc("rm_lw", 0, 0, 0, 0);
    drive(1'b1, enc_r(5'd2, 5'd4, 5'd3), 32'h8);
    @(negedge clk);
    chk("rm.pre_stall", 64'(if_stall), 64'd1);
    #1 rst = 1'b0;
    #1 chk_reset("rst_mid");
    @(posedge clk);
    #1;
    chk_reset("rst_mid_edge");
    rst = 1'b1;
    expect_txn(32'h8, 32'h0, 32'h0, 32'h1820, 5'd2, 5'd4, 5'd3, 5'd3, 4'b1100, 3'b000, 2'b10, 1'b0);
    cyc("rm_add", 0, 0, 0, 0);
    chk("rm.stall_count", 64'(stall_count), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    cyc("drain1", 0, 0, 0, 0);
    cyc("drain2", 0, 0, 0, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised instruction-decode stage for the 5-stage MIPS pipeline, the successor to the fixed 32-bit ID stage. It decodes the IF/ID instruction, reads the register file, resolves `beq`/`bne`/`j` in ID with combinational redirect, and detects load-use and branch-operand hazards itself, stalling IF and inserting bubbles. It owns the ID/EX pipeline register and feeds the EX stage directly.

## Interface
- `XLEN`, 32: datapath width (32 or 64). The immediate is sign-extended to XLEN.
- `BRANCH_FWD`, 1: 1 forwards the MEM-stage ALU result into the branch comparator; 0 stalls instead.
- `CNT_W`, 16: width of the stall performance counter.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `if_valid` in 1: IF/ID holds a real instruction.
- `if_pc4` in XLEN: PC+4 of the IF/ID instruction.
- `if_instr` in 32: IF/ID instruction.
- `mem_regwrite`, `mem_memread` in 1: MEM-stage control.
- `mem_dst` in 5: MEM-stage destination register.
- `mem_alu` in XLEN: MEM-stage ALU result.
- `wb_regwrite` in 1: writeback enable.
- `wb_dst` in 5: writeback register.
- `wb_data` in XLEN: writeback data.
- `if_stall` out 1: hold PC and IF/ID this cycle.
- `if_flush` out 1: load a bubble into IF/ID at the next edge.
- `redirect_valid` out 1: take `redirect_pc` at the next edge.
- `redirect_pc` out XLEN: branch or jump target.
- `id_ex_valid`, `id_ex_illegal` out 1: ID/EX valid flag and unknown-opcode flag.
- `id_ex_pc4`, `id_ex_rd1`, `id_ex_rd2`, `id_ex_imm` out XLEN: ID/EX data.
- `id_ex_rs`, `id_ex_rt`, `id_ex_rd`, `id_ex_dst` out 5 each: register fields. `dst` is `rd` for R-type and `rt` otherwise.
- `id_ex_ex` out 4: `{RegDst, ALUOp[1:0], ALUSrc}`.
- `id_ex_mem` out 3: `{Branch, MemRead, MemWrite}`.
- `id_ex_wb` out 2: `{RegWrite, MemtoReg}`.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
- **Decoded opcodes:** R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, addi 0x08.
  - Any other opcode is decoded with zero control and `illegal=1`.
  - `if_valid=0` decodes as a bubble.
- **Source usage:**
  - rs is used by every opcode except j.
  - rt is used by R-type, sw, beq and bne.
  - Register 0 never creates a hazard and never forwards.
- **Load-use stall:** `id_ex_valid & id_ex_mem[1] & id_ex_dst!=0` and `id_ex_dst` matches a used source.
- **Branch stall (beq/bne only)**, when any of these holds:
  - `id_ex_valid & id_ex_wb[1]` and `id_ex_dst` matches rs or rt.
  - `mem_memread` and `mem_dst` matches rs or rt.
  - `mem_regwrite & !mem_memread` and `mem_dst` matches rs or rt, with `BRANCH_FWD=0`.
- **Branch forwarding:** with `BRANCH_FWD=1`, that last case selects `mem_alu` as the comparator operand instead of stalling.
- **WB bypass:** handled inside the register file. A same-cycle write is visible to the read.
- **On stall:**
  - `if_stall=1`.
  - The ID/EX register loads a bubble: valid=0, all control=0, data don't-care.
  - Redirect is suppressed.
  - `stall_count` increments, saturating at all-ones.
- **Redirect (no stall, valid decode):**
  - j: `redirect_pc = {if_pc4[XLEN-1:28], instr[25:0], 2'b00}`.
  - beq taken when the operands are equal; bne taken when they are unequal.
  - Branch target: `redirect_pc = if_pc4 + (imm << 2)`, wrapping modulo 2^XLEN.
  - A taken branch or j asserts `redirect_valid=1` and `if_flush=1` in the same cycle.
  - The branch or jump itself still enters ID/EX as valid. For j, all control is zero.
- **No stall:** ID/EX loads the decoded bundle.

## Timing
- `if_stall`, `if_flush`, `redirect_valid` and `redirect_pc` are combinational from the current inputs and ID/EX state.
- Branch penalty is 1 cycle. Load-use stall is 1 cycle.
- A branch depending on a load directly ahead of it stalls 2 cycles.
- A branch depending on an ALU op directly ahead of it:
  - stalls 1 cycle with `BRANCH_FWD=1`;
  - stalls 2 cycles with `BRANCH_FWD=0`.
- ID/EX latency: 1 edge.
- Register file: synchronous write on the rising edge, asynchronous read.
- **Reset (rst low, asynchronous):**
  - All `id_ex_*` outputs are 0 and `stall_count` is 0.
  - `if_stall`, `if_flush` and `redirect_valid` are forced to 0.
  - All registers are cleared.
  - A reset asserted mid-stall abandons the stall.
- Stall and redirect are never both asserted in a cycle; stall has priority.

## Structure
- Package `id_pkg` holds:
  - opcode constants;
  - control bit-position localparams for the EX, MEM and WB fields;
  - field widths, including `REG_W=5`.
- Sub-module `regfile_2r1w`:
  - 32×XLEN, 2 read ports, 1 write port;
  - write-first bypass;
  - writes to r0 are ignored and r0 reads as 0;
  - asynchronous reset clears all registers.

## Test plan
- **Reset:** drive rst low mid-stream → all ID/EX outputs 0, `stall_count=0`, redirect 0. Release rst → the next valid instruction issues normally.
- **Load-use:** `lw $2,0($1)` then `add $3,$2,$4` → one cycle with `if_stall=1` and an ID/EX bubble, then add issues. `stall_count=1`.
- **Branch on ALU result, `BRANCH_FWD=1`:** `add $5` (mem_alu=7), nop, then `beq $5,$6` with $6=7, imm=4, pc4=0x100 → no stall, `redirect_pc=0x110`, `if_flush=1`. With `BRANCH_FWD=0` → 1 stall cycle first.
- **Branch after load:** `lw $8` immediately followed by `bne $8,$0` → 2 stall cycles, then resolution. `stall_count=2`.
- **Jump:** `j` with index 0x0100000, pc4=0x8000_0004 → `redirect_pc=0x8040_0000`, `if_flush=1`, ID/EX valid with zero control.
- **WB bypass:** `wb_regwrite` for $7=0xDEAD_BEEF in the same cycle as an instruction reading $7 → `id_ex_rd1=0xDEAD_BEEF` at the next edge. A write to $0 → reads 0.
